// File: rtl/jac_decoder.sv
// -----------------------------------------------------------------------------
// jac_decoder
//   Instruction decoder of the Jac1-8 8-bit CPU. Splits a 16-bit instruction
//   into its fields and produces every datapath control signal for that
//   instruction combinationally. A single clocked sticky flag remembers that a
//   reserved opcode has been decoded since the last reset.
//
// Ports
//   clk                      clock, used only by the illegal_op flag
//   reset                    asynchronous, active-high reset
//   instruction[15:0]        current instruction from program memory
//   status[2:0]              status register: [2]=zero [1]=greater [0]=smaller
//   opcode[4:0]              instruction[15:11]
//   param[7:0]               instruction[7:0] (immediate / shift amount)
//   literal_adr[7:0]         instruction[7:0] (jump target or relative offset)
//   rd_sel1/rd_sel2[1:0]     register read port selects
//   rd_en1/rd_en2            register read port enables
//   wr_en, wr_sel[1:0]       register write enable / select
//   sel_reg_in_alu_decoder   write source: 1 = ALU, 0 = decoder param
//   cnt_wr_en                program counter load enable
//   add_offset               1 = relative PC update, 0 = absolute load
//   stat_wr_en               status register write enable
//   stat_reg_in_alu_decoder  status source, always ALU (1)
//   status_out[2:0]          decoder-sourced status, always 000
//   illegal_op               sticky: a reserved opcode was decoded
// -----------------------------------------------------------------------------
module jac_decoder #(
    parameter int DataWidth         = 8,
    parameter int SEL_WIDTH         = 2,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int ParamBits         = 8,
    parameter int NumStatusBits     = 3,
    parameter int OP1_BIT_POS       = 9,
    parameter int OP2_BIT_POS       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic [NumStatusBits-1:0]     status,
    output logic [NumOpCodeBits-1:0]     opcode,
    output logic [ParamBits-1:0]         param,
    output logic [DataWidth-1:0]         literal_adr,
    output logic [SEL_WIDTH-1:0]         rd_sel1,
    output logic [SEL_WIDTH-1:0]         rd_sel2,
    output logic                         rd_en1,
    output logic                         rd_en2,
    output logic                         wr_en,
    output logic [SEL_WIDTH-1:0]         wr_sel,
    output logic                         sel_reg_in_alu_decoder,
    output logic                         cnt_wr_en,
    output logic                         add_offset,
    output logic                         stat_wr_en,
    output logic                         stat_reg_in_alu_decoder,
    output logic [NumStatusBits-1:0]     status_out,
    output logic                         illegal_op
);

    typedef enum logic [NumOpCodeBits-1:0] {
        OP_NOP  = 'h00,
        OP_ADD  = 'h01,
        OP_SUB  = 'h02,
        OP_AND  = 'h03,
        OP_OR   = 'h04,
        OP_NOT  = 'h05,
        OP_XOR  = 'h06,
        OP_SHL  = 'h07,
        OP_SHR  = 'h08,
        OP_VAL  = 'h09,
        OP_GOTO = 'h10,
        OP_IFZ  = 'h11,
        OP_IFNZ = 'h12,
        OP_IFEQ = 'h13,
        OP_IFST = 'h14,
        OP_IFGT = 'h15
    } opcode_t;

    localparam int StatZero    = 2;
    localparam int StatGreater = 1;
    localparam int StatSmaller = 0;

    opcode_t              w_op;
    logic [SEL_WIDTH-1:0] w_op1;
    logic [SEL_WIDTH-1:0] w_op2;
    logic                 w_reserved;
    logic                 r_illegal;

    // Field taps are unconditional: they stay valid even while reset is held.
    assign opcode      = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign param       = instruction[ParamBits-1:0];
    assign literal_adr = instruction[DataWidth-1:0];
    assign w_op        = opcode_t'(opcode);
    assign w_op1       = instruction[OP1_BIT_POS -: SEL_WIDTH];
    // op2 deliberately overlaps the low byte used as param.
    assign w_op2       = instruction[OP2_BIT_POS -: SEL_WIDTH];

    assign stat_reg_in_alu_decoder = 1'b1;
    assign status_out              = '0;

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // that no path leaves it unassigned, which would infer a latch.
        rd_sel1                = '0;
        rd_sel2                = '0;
        rd_en1                 = 1'b0;
        rd_en2                 = 1'b0;
        wr_en                  = 1'b0;
        wr_sel                 = '0;
        sel_reg_in_alu_decoder = 1'b0;
        cnt_wr_en              = 1'b0;
        add_offset             = 1'b0;
        stat_wr_en             = 1'b0;
        w_reserved             = 1'b0;

        case (w_op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                rd_sel1                = w_op1;
                rd_en1                 = 1'b1;
                rd_sel2                = w_op2;
                rd_en2                 = 1'b1;
                sel_reg_in_alu_decoder = 1'b1;
                wr_en                  = 1'b1;
                wr_sel                 = w_op1;
                stat_wr_en             = 1'b1;
            end
            OP_NOT: begin
                // Unary: the operand comes in on port 2, result goes to op1.
                rd_sel2                = w_op2;
                rd_en2                 = 1'b1;
                sel_reg_in_alu_decoder = 1'b1;
                wr_en                  = 1'b1;
                wr_sel                 = w_op1;
                stat_wr_en             = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                // Shift amount reaches the ALU through param, not port 2.
                rd_sel1                = w_op1;
                rd_en1                 = 1'b1;
                sel_reg_in_alu_decoder = 1'b1;
                wr_en                  = 1'b1;
                wr_sel                 = w_op1;
                stat_wr_en             = 1'b1;
            end
            OP_VAL: begin
                wr_en  = 1'b1;
                wr_sel = w_op1;
            end
            OP_GOTO: cnt_wr_en = 1'b1;
            OP_IFZ, OP_IFEQ: begin
                cnt_wr_en  = status[StatZero];
                add_offset = status[StatZero];
            end
            OP_IFNZ: begin
                cnt_wr_en  = ~status[StatZero];
                add_offset = ~status[StatZero];
            end
            OP_IFST: begin
                cnt_wr_en  = status[StatSmaller];
                add_offset = status[StatSmaller];
            end
            OP_IFGT: begin
                cnt_wr_en  = status[StatGreater];
                add_offset = status[StatGreater];
            end
            default: w_reserved = 1'b1;
        endcase

        // Reset overrides the decode immediately, without waiting for a clock.
        if (reset) begin
            rd_sel1                = '0;
            rd_sel2                = '0;
            rd_en1                 = 1'b0;
            rd_en2                 = 1'b0;
            wr_en                  = 1'b0;
            wr_sel                 = '0;
            sel_reg_in_alu_decoder = 1'b0;
            cnt_wr_en              = 1'b0;
            add_offset             = 1'b0;
            stat_wr_en             = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_reserved) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_jac_decoder.sv
module tb_jac_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic [2:0]  status;
    logic [4:0]  opcode;
    logic [7:0]  param;
    logic [7:0]  literal_adr;
    logic [1:0]  rd_sel1, rd_sel2, wr_sel;
    logic        rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder;
    logic        cnt_wr_en, add_offset, stat_wr_en, stat_reg_in_alu_decoder;
    logic [2:0]  status_out;
    logic        illegal_op;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_ill;

    jac_decoder dut (
        .clk                     (clk),
        .reset                   (reset),
        .instruction             (instruction),
        .status                  (status),
        .opcode                  (opcode),
        .param                   (param),
        .literal_adr             (literal_adr),
        .rd_sel1                 (rd_sel1),
        .rd_sel2                 (rd_sel2),
        .rd_en1                  (rd_en1),
        .rd_en2                  (rd_en2),
        .wr_en                   (wr_en),
        .wr_sel                  (wr_sel),
        .sel_reg_in_alu_decoder  (sel_reg_in_alu_decoder),
        .cnt_wr_en               (cnt_wr_en),
        .add_offset              (add_offset),
        .stat_wr_en              (stat_wr_en),
        .stat_reg_in_alu_decoder (stat_reg_in_alu_decoder),
        .status_out              (status_out),
        .illegal_op              (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t ins=%h st=%b rst=%b)",
                     tag, got, exp, $time, instruction, status, reset);
        end
    endtask

    // Control vector layout (MSB..LSB):
    // rd_sel1 rd_sel2 rd_en1 rd_en2 wr_en wr_sel sel_alu cnt add stat_wr stat_src status_out
    function automatic logic [16:0] pack(
        input logic [1:0] rs1, input logic [1:0] rs2, input logic e1, input logic e2,
        input logic we, input logic [1:0] ws, input logic sa, input logic cw,
        input logic ao, input logic sw, input logic ss, input logic [2:0] so);
        return {rs1, rs2, e1, e2, we, ws, sa, cw, ao, sw, ss, so};
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return pack(rd_sel1, rd_sel2, rd_en1, rd_en2, wr_en, wr_sel, sel_reg_in_alu_decoder,
                    cnt_wr_en, add_offset, stat_wr_en, stat_reg_in_alu_decoder, status_out);
    endfunction

    function automatic bit is_reserved(input logic [4:0] op);
        return (op >= 5'h0A && op <= 5'h0F) || op >= 5'h16;
    endfunction

    // Reference model: instruction classes by opcode range, written from the
    // instruction-set rules rather than as a per-opcode decode table.
    function automatic logic [16:0] model(input logic [15:0] ins, input logic [2:0] st,
                                          input logic rst);
        int op;
        logic [1:0] op1, op2, rs1, rs2, ws;
        logic e1, e2, we, sa, cw, ao, sw, cond;
        op  = int'(ins[15:11]);
        op1 = ins[9:8];
        op2 = ins[4:3];
        {rs1, rs2, ws} = '0;
        {e1, e2, we, sa, cw, ao, sw} = '0;
        if (!rst) begin
            if (op >= 1 && op <= 8) begin
                // ALU class: result to op1, status updated.
                we = 1; ws = op1; sa = 1; sw = 1;
                if (op != 5) begin rs1 = op1; e1 = 1; end
                if (op <= 6) begin rs2 = op2; e2 = 1; end
            end else if (op == 9) begin
                we = 1; ws = op1;
            end else if (op == 16) begin
                cw = 1;
            end else if (op >= 17 && op <= 21) begin
                case (op)
                    17, 19:  cond = st[2];
                    18:      cond = !st[2];
                    20:      cond = st[0];
                    default: cond = st[1];
                endcase
                cw = cond; ao = cond;
            end
        end
        return pack(rs1, rs2, e1, e2, we, ws, sa, cw, ao, sw, 1'b1, 3'b000);
    endfunction

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] op1,
                                       input logic [7:0] prm);
        return {op, 1'b0, op1, prm};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":ctrl"}, 32'(dut_ctrl()), 32'(model(instruction, status, reset)));
        check({tag, ":opcode"}, 32'(opcode), 32'(instruction[15:11]));
        check({tag, ":param"}, 32'(param), 32'(instruction[7:0]));
        check({tag, ":lit"}, 32'(literal_adr), 32'(instruction[7:0]));
        check({tag, ":ill"}, 32'(illegal_op), 32'(exp_ill));
    endtask

    task automatic apply(input logic [15:0] ins, input logic [2:0] st);
        instruction = ins;
        status      = st;
        #1;
    endtask

    // One clock edge; the sticky flag is updated from the inputs at the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset && is_reserved(instruction[15:11])) exp_ill = 1'b1;
        #2;
        check("tick:ill", 32'(illegal_op), 32'(exp_ill));
    endtask

    initial begin
        logic [4:0] op;
        reset       = 1'b1;
        instruction = '0;
        status      = '0;
        exp_ill     = 1'b0;
        #3;
        check("rst:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("rst:ill", 32'(illegal_op), 32'(0));
        reset = 1'b0;
        #1;
        check("nop:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));

        // ADD r1, r2 with literal expectations.
        apply(mk(5'h01, 2'b01, {3'b0, 2'b10, 3'b0}), 3'b000);
        check("add:ctrl", 32'(dut_ctrl()), 32'(pack(2'b01, 2'b10, 1, 1, 1, 2'b01, 1, 0, 0, 1, 1, 0)));
        apply(mk(5'h02, 2'b11, {3'b0, 2'b00, 3'b0}), 3'b101); check_all("sub");
        apply(mk(5'h03, 2'b10, {3'b0, 2'b01, 3'b0}), 3'b010); check_all("and");
        apply(mk(5'h04, 2'b00, {3'b0, 2'b11, 3'b0}), 3'b000); check_all("or");
        apply(mk(5'h06, 2'b01, {3'b0, 2'b01, 3'b0}), 3'b111); check_all("xor");

        apply(mk(5'h05, 2'b10, 8'h00), 3'b000);
        check("not:ctrl", 32'(dut_ctrl()), 32'(pack(2'b00, 2'b00, 0, 1, 1, 2'b10, 1, 0, 0, 1, 1, 0)));
        apply(mk(5'h07, 2'b01, 8'h05), 3'b000);
        check("shl:ctrl", 32'(dut_ctrl()), 32'(pack(2'b01, 2'b00, 1, 0, 1, 2'b01, 1, 0, 0, 1, 1, 0)));
        apply(mk(5'h08, 2'b11, 8'h1F), 3'b000); check_all("shr");

        apply(mk(5'h09, 2'b11, 8'hA5), 3'b111);
        check("val:param", 32'(param), 32'h0A5);
        check("val:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 1, 0)));
        apply(mk(5'h10, 2'b00, 8'h3F), 3'b111);
        check("goto:lit", 32'(literal_adr), 32'h03F);
        check("goto:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0)));

        // Conditional jumps with their status bit low and high.
        apply(mk(5'h11, 2'b00, 8'hF0), 3'b000);
        check("ifz0:cnt_add", 32'({cnt_wr_en, add_offset}), 32'b00);
        apply(mk(5'h11, 2'b00, 8'hF0), 3'b100);
        check("ifz1:cnt_add", 32'({cnt_wr_en, add_offset}), 32'b11);
        apply(mk(5'h12, 2'b00, 8'hF0), 3'b000);
        check("ifnz0:cnt_add", 32'({cnt_wr_en, add_offset}), 32'b11);
        apply(mk(5'h12, 2'b00, 8'hF0), 3'b100);
        check("ifnz1:cnt_add", 32'({cnt_wr_en, add_offset}), 32'b00);
        for (int c = 0; c < 2; c++) begin
            apply(mk(5'h13, 2'b00, 8'h10), c[0] ? 3'b100 : 3'b011); check_all("ifeq");
            apply(mk(5'h14, 2'b00, 8'h10), c[0] ? 3'b001 : 3'b110); check_all("ifst");
            apply(mk(5'h15, 2'b00, 8'h10), c[0] ? 3'b010 : 3'b101); check_all("ifgt");
        end

        // NOP across a clock edge must not set the flag.
        apply(16'h0000, 3'b000);
        tick();
        // Reserved opcode 0Ah: no enables, flag set on the edge.
        apply(mk(5'h0A, 2'b11, 8'hFF), 3'b111);
        check("res:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("res:ill_pre", 32'(illegal_op), 32'(0));
        tick();
        check("res:ill_set", 32'(illegal_op), 32'(1));
        apply(mk(5'h01, 2'b10, {3'b0, 2'b11, 3'b0}), 3'b000);
        tick();
        check("hold:ill", 32'(illegal_op), 32'(1));
        // Reset mid-ADD: enables and flag drop with no clock edge.
        reset   = 1'b1;
        exp_ill = 1'b0;
        #1;
        check("rst_mid:ctrl", 32'(dut_ctrl()), 32'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
        check("rst_mid:ill", 32'(illegal_op), 32'(0));
        check("rst_mid:opcode", 32'(opcode), 32'h01);
        reset = 1'b0;
        #1;
        check_all("rst_rel");

        // Randomized stimulus against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset   = 1'b1;
                exp_ill = 1'b0;
                #1;
                check_all("rnd_rst");
                reset = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
            else                           op = 5'($urandom_range(0, 21));
            apply({op, 11'($urandom)}, 3'($urandom));
            check_all("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jac_decoder.md
Name: jac_decoder

Overview:
Instruction decoder of the Jac1-8 8-bit CPU. It sits between program memory and the register file, ALU, status register and program counter. It splits each 16-bit instruction into its fields and generates all datapath control signals for one instruction combinationally. A clocked sticky flag records when a reserved opcode has been decoded.

Parameters:
DataWidth, 8, data/address width; width of literal_adr
SEL_WIDTH, 2, register select width (4 registers)
PROGRAM_DataWidth, 16, instruction width
NumOpCodeBits, 5, opcode width
ParamBits, 8, immediate width
NumStatusBits, 3, status width
OP1_BIT_POS, 9, MSB of operand-1 field
OP2_BIT_POS, 4, MSB of operand-2 field

Ports:
clk  in  1  clock; used only by illegal_op
reset  in  1  asynchronous, active-high reset
instruction  in  16  current instruction
status  in  3  status register: [2]=zero, [1]=greater, [0]=smaller
opcode  out  5  instruction[15:11]
param  out  8  instruction[7:0]
literal_adr  out  8  instruction[7:0]; absolute jump target / relative offset
rd_sel1  out  2  register read port 1 select
rd_sel2  out  2  register read port 2 select
rd_en1  out  1  read port 1 enable
rd_en2  out  1  read port 2 enable
wr_en  out  1  register write enable
wr_sel  out  2  register write select
sel_reg_in_alu_decoder  out  1  register write source: 1 = ALU, 0 = decoder param
cnt_wr_en  out  1  program counter load enable
add_offset  out  1  1 = PC adds literal_adr as a relative offset; 0 = absolute load
stat_wr_en  out  1  status register write enable
stat_reg_in_alu_decoder  out  1  status source; constant 1 (ALU)
status_out  out  3  decoder-sourced status; constant 3'b000
illegal_op  out  1  sticky flag: a reserved opcode was decoded

Behaviour:
- Field split: op1 = instruction[9:8]; op2 = instruction[4:3]; op2 overlaps param by design.
- opcode, param, literal_adr: pure field taps, always driven regardless of opcode or reset.
- Default for every opcode: rd_sel1/rd_sel2/wr_sel = 0; all enables = 0; sel_reg_in_alu_decoder = 0; add_offset = 0.
- ADD 01, SUB 02, AND 03, OR 04, XOR 06:
  - rd_sel1 = op1, rd_sel2 = op2, rd_en1 = rd_en2 = 1.
  - sel_reg_in_alu_decoder = 1; wr_en = 1, wr_sel = op1; stat_wr_en = 1.
- NOT 05:
  - rd_en1 = 0, rd_sel1 = 0; rd_sel2 = op2, rd_en2 = 1.
  - sel_reg_in_alu_decoder = 1; wr_en = 1, wr_sel = op1; stat_wr_en = 1.
- SHL 07, SHR 08:
  - rd_sel1 = op1, rd_en1 = 1; rd_en2 = 0, rd_sel2 = 0.
  - Shift amount is taken from param by the ALU.
  - sel_reg_in_alu_decoder = 1; wr_en = 1, wr_sel = op1; stat_wr_en = 1.
- VAL 09: no reads; sel_reg_in_alu_decoder = 0; wr_en = 1, wr_sel = op1; stat_wr_en = 0.
- GOTO 10h: cnt_wr_en = 1, add_offset = 0; no register reads or writes.
- Conditional relative jumps: cnt_wr_en = add_offset = condition. No register or status writes.
  - IFZ 11h: condition = status[2].
  - IFNZ 12h: condition = ~status[2].
  - IFEQ 13h: condition = status[2].
  - IFST 14h: condition = status[0].
  - IFGT 15h: condition = status[1].
- NOP 00 and reserved opcodes 0Ah–0Fh, 16h–1Fh: all defaults (no side effects).
- stat_reg_in_alu_decoder = 1 and status_out = 000 at all times.
- Control outputs follow instruction and status with zero clock latency.
- Reset asserted (asynchronous): all enables (rd_en1, rd_en2, wr_en, cnt_wr_en, stat_wr_en, add_offset) forced to 0 and all selects forced to 0; illegal_op cleared to 0 immediately. Decoding resumes combinationally on deassert.
- illegal_op: set on a rising clk edge when opcode is reserved; stays set until reset. NOP does not set it.

Test Plan:
- instruction = 0, status = 0, reset low -> stat_wr_en 0, status_out 000, stat_reg_in_alu_decoder 1, all enables 0.
- ADD with op1 = 01, op2 = 10 -> rd_sel1 01, rd_sel2 10, rd_en1 = rd_en2 = 1, wr_en 1, wr_sel 01, sel_reg_in_alu_decoder 1, stat_wr_en 1, add_offset 0. Repeat for SUB/AND/OR/XOR with other register pairs.
- NOT with op1 = 10, op2 = 00 -> rd_en1 0, rd_sel1 00, rd_en2 1, wr_sel 10, stat_wr_en 1. SHL with op1 = 01, param = 05 -> rd_sel1 01, rd_en1 1, rd_en2 0, wr_sel 01.
- VAL with op1 = 11, param = A5 -> param A5, wr_en 1, wr_sel 11, sel_reg_in_alu_decoder 0, stat_wr_en 0, no reads. GOTO with param = 3F -> literal_adr 3F, cnt_wr_en 1, add_offset 0, wr_en 0.
- IFZ with status[2] = 0 -> cnt_wr_en = add_offset = 0; with status[2] = 1 -> both 1. IFNZ gives the inverse for each status value. IFEQ/IFST/IFGT each checked with their status bit at 0 and at 1.
- Reserved opcode 0Ah, then one clk edge -> illegal_op 1, no enables, flag holds through a later ADD. Assert reset mid-ADD -> enables drop to 0 immediately and illegal_op clears.
